// File: rtl/vga_pkg.sv
// Shared VGA definitions: counter/colour widths, default active area, palette
// constants and the configuration handshake state type.
package vga_pkg;

  localparam int COLOR_W  = 12;
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  localparam int H_ACTIVE_DEFAULT = 800;
  localparam int V_ACTIVE_DEFAULT = 600;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t COLOR_BLACK = 12'h000;
  localparam color_t COLOR_WHITE = 12'hFFF;
  localparam color_t COLOR_KEY   = 12'hF0F;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_e;

endpackage

// File: rtl/pixel_layer_arb_if.sv
// Frame-synchronous configuration handshake between a requester (master)
// and the layer arbiter (slave).
interface pixel_layer_arb_if
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) ();

  logic                  cfg_req;
  logic [NUM_LAYERS-1:0] cfg_enable;
  color_t                cfg_bg;
  logic                  cfg_ack;

  modport master (output cfg_req, cfg_enable, cfg_bg, input cfg_ack);
  modport slave  (input cfg_req, cfg_enable, cfg_bg, output cfg_ack);

endinterface

// File: rtl/layer_prio_sel.sv
// Combinational priority mux: the lowest-index qualified layer wins,
// otherwise the background colour is passed through.
module layer_prio_sel
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0]         qual,
  input  logic [COLOR_W*NUM_LAYERS-1:0] pixels,
  input  color_t                        bg,
  output color_t                        color
);

  always_comb begin
    // NOTE: assigning a default before any conditional keeps this purely
    // combinational; a path that leaves color unassigned would infer a latch.
    color = bg;
    // Walk from lowest to highest priority so the final overwrite is index 0.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (qual[i]) color = pixels[COLOR_W*i +: COLOR_W];
    end
  end

endmodule

// File: rtl/pixel_layer_arb.sv
// Two-stage per-pixel layer arbiter with a frame-synchronous configuration
// handshake (enables and background only change at pixel (0,0)).
module pixel_layer_arb
  import vga_pkg::*;
#(
  parameter int     NUM_LAYERS = 4,
  parameter int     H_ACTIVE   = H_ACTIVE_DEFAULT,
  parameter int     V_ACTIVE   = V_ACTIVE_DEFAULT,
  parameter color_t KEY_COLOR  = COLOR_KEY,
  parameter color_t BG_DEFAULT = COLOR_BLACK
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [HCOUNT_W-1:0]           hcount,
  input  logic [VCOUNT_W-1:0]           vcount,
  input  logic [NUM_LAYERS-1:0]         layer_valid,
  input  logic [COLOR_W*NUM_LAYERS-1:0] layer_pixel,
  pixel_layer_arb_if.slave              cfg,
  output color_t                        pixel_out,
  output logic                          frame_start,
  output logic [15:0]                   frame_cnt
);

  logic [HCOUNT_W-1:0]           h_q;
  logic [VCOUNT_W-1:0]           v_q;
  logic [NUM_LAYERS-1:0]         valid_q;
  logic [COLOR_W*NUM_LAYERS-1:0] pix_q;

  cfg_state_e            state, state_next;
  logic                  cfg_req_d;
  logic [NUM_LAYERS-1:0] shadow_en, en_active, en_eff;
  color_t                shadow_bg, bg_active, bg_eff;
  logic                  cfg_rise, boundary, apply, in_active;
  logic [NUM_LAYERS-1:0] qual;
  color_t                sel_color;

  // Stage 0. Coordinates reset to all-ones so the first cycle after reset is
  // neither active nor mistaken for a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      h_q     <= '1;
      v_q     <= '1;
      valid_q <= '0;
      pix_q   <= '0;
    end else begin
      h_q     <= hcount;
      v_q     <= vcount;
      valid_q <= layer_valid;
      pix_q   <= layer_pixel;
    end
  end

  assign cfg_rise  = cfg.cfg_req & ~cfg_req_d;
  assign boundary  = (h_q == '0) && (v_q == '0);
  assign in_active = (h_q < HCOUNT_W'(H_ACTIVE)) && (v_q < VCOUNT_W'(V_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CFG_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    apply      = 1'b0;
    if (state == CFG_PENDING && boundary) begin
      apply      = 1'b1;
      state_next = CFG_IDLE;
    end
    // A new request always leaves a shadow waiting, even when the old one
    // is being applied in this same cycle.
    if (cfg_rise) state_next = CFG_PENDING;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_req_d   <= 1'b0;
      shadow_en   <= '1;
      shadow_bg   <= BG_DEFAULT;
      en_active   <= '1;
      bg_active   <= BG_DEFAULT;
      cfg.cfg_ack <= 1'b0;
    end else begin
      cfg_req_d   <= cfg.cfg_req;
      cfg.cfg_ack <= apply;
      if (apply) begin
        en_active <= shadow_en;
        bg_active <= shadow_bg;
      end
      if (cfg_rise) begin
        shadow_en <= cfg.cfg_enable;
        shadow_bg <= cfg.cfg_bg;
      end
    end
  end

  // Bypass so the configuration applied at the boundary already governs (0,0).
  assign en_eff = apply ? shadow_en : en_active;
  assign bg_eff = apply ? shadow_bg : bg_active;

  always_comb begin
    qual = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      qual[i] = valid_q[i] & en_eff[i] & (pix_q[COLOR_W*i +: COLOR_W] != KEY_COLOR);
    end
  end

  layer_prio_sel #(.NUM_LAYERS(NUM_LAYERS)) u_sel (
    .qual   (qual),
    .pixels (pix_q),
    .bg     (bg_eff),
    .color  (sel_color)
  );

  // Stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out   <= COLOR_BLACK;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pixel_out   <= in_active ? sel_color : COLOR_BLACK;
      frame_start <= boundary;
      frame_cnt   <= frame_cnt + 16'(boundary);
    end
  end

endmodule

// File: tb/tb_pixel_layer_arb.sv
// Scoreboard bench for pixel_layer_arb: a transaction model pushes the
// expected output for each driven pixel; entries are popped two cycles later.
module tb_pixel_layer_arb;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [3:0]  layer_valid;
  logic [47:0] layer_pixel;
  color_t      pixel_out;
  logic        frame_start;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  pixel_layer_arb_if #(.NUM_LAYERS(4)) cfg_if ();

  pixel_layer_arb #(
    .NUM_LAYERS (4),
    .H_ACTIVE   (800),
    .V_ACTIVE   (600),
    .KEY_COLOR  (12'hF0F),
    .BG_DEFAULT (12'h000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .layer_valid (layer_valid),
    .layer_pixel (layer_pixel),
    .cfg         (cfg_if.slave),
    .pixel_out   (pixel_out),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  typedef struct {
    color_t      pix;
    logic        fs;
    logic        ack;
    logic [15:0] fcnt;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // Reference model state.
  logic        m_pend, m_req_d, m_prev_bnd;
  logic [3:0]  m_sh_en, m_en;
  color_t      m_sh_bg, m_bg;
  logic [15:0] m_fcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  function automatic logic [47:0] px(input color_t p3, input color_t p2,
                                     input color_t p1, input color_t p0);
    return {p3, p2, p1, p0};
  endfunction

  function automatic color_t ref_pix(input logic [10:0] h, input logic [9:0] v,
                                     input logic [3:0] val, input logic [47:0] pix,
                                     input logic [3:0] en, input color_t bg);
    color_t c;
    if (h >= 11'd800 || v >= 10'd600) return 12'h000;
    for (int i = 0; i < 4; i++) begin
      c = pix[12*i +: 12];
      if (val[i] && en[i] && c != 12'hF0F) return c;
    end
    return bg;
  endfunction

  task automatic model_reset();
    m_pend     = 1'b0;
    m_req_d    = 1'b0;
    m_prev_bnd = 1'b0;
    m_sh_en    = 4'hF;
    m_en       = 4'hF;
    m_sh_bg    = 12'h000;
    m_bg       = 12'h000;
    m_fcnt     = 16'd0;
    sb.delete();
  endtask

  task automatic step(input logic [10:0] h, input logic [9:0] v, input logic [3:0] val,
                      input logic [47:0] pix, input logic req, input logic [3:0] en,
                      input color_t bg);
    exp_t       e;
    logic       apply_next, bnd;
    logic [3:0] en_eff;
    color_t     bg_eff;
    hcount            = h;
    vcount            = v;
    layer_valid       = val;
    layer_pixel       = pix;
    cfg_if.cfg_req    = req;
    cfg_if.cfg_enable = en;
    cfg_if.cfg_bg     = bg;
    // Effects of the upcoming edge: apply a pending shadow at a boundary,
    // then capture a new request.
    if (m_pend && m_prev_bnd) begin
      m_en   = m_sh_en;
      m_bg   = m_sh_bg;
      m_pend = 1'b0;
    end
    if (req && !m_req_d) begin
      m_sh_en = en;
      m_sh_bg = bg;
      m_pend  = 1'b1;
    end
    m_req_d = req;
    // Expected result for this pixel, decided one edge later.
    bnd        = (h == 11'd0) && (v == 10'd0);
    apply_next = m_pend && bnd;
    en_eff     = apply_next ? m_sh_en : m_en;
    bg_eff     = apply_next ? m_sh_bg : m_bg;
    if (bnd) m_fcnt = m_fcnt + 16'd1;
    e.pix  = ref_pix(h, v, val, pix, en_eff, bg_eff);
    e.fs   = bnd;
    e.ack  = apply_next;
    e.fcnt = m_fcnt;
    m_prev_bnd = bnd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check("pixel_out", 32'(pixel_out), 32'(e.pix));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("cfg_ack", 32'(cfg_if.cfg_ack), 32'(e.ack));
      check("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
    end
  endtask

  task automatic idle(input logic req);
    step(11'd1000, 10'd700, 4'h0, 48'h0, req, 4'h0, 12'h000);
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    hcount            = 11'd0;
    vcount            = 10'd0;
    layer_valid       = 4'h0;
    layer_pixel       = 48'h0;
    cfg_if.cfg_req    = 1'b0;
    cfg_if.cfg_enable = 4'h0;
    cfg_if.cfg_bg     = 12'h000;
    #1;
    check("rst.pixel_out", 32'(pixel_out), 32'h0);
    check("rst.cfg_ack", 32'(cfg_if.cfg_ack), 32'h0);
    check("rst.frame_start", 32'(frame_start), 32'h0);
    check("rst.frame_cnt", 32'(frame_cnt), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b1;
    #2;
    phase = "reset";
    do_reset();

    phase = "t1_prio";
    step(11'd10, 10'd40, 4'b1110, px(12'hABC, 12'h456, 12'h0F0, 12'h000), 1'b0, 4'h0, 12'h000);
    step(11'd11, 10'd40, 4'b1100, px(12'hABC, 12'h456, 12'h0F0, 12'h000), 1'b0, 4'h0, 12'h000);

    phase = "t2_key";
    step(11'd12, 10'd40, 4'b0101, px(12'h000, 12'h00F, 12'h000, 12'hF0F), 1'b0, 4'h0, 12'h000);
    step(11'd13, 10'd40, 4'b0000, px(12'h111, 12'h222, 12'h333, 12'h444), 1'b0, 4'h0, 12'h000);

    phase = "t3_blank";
    step(11'd800, 10'd40,  4'b0001, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b0, 4'h0, 12'h000);
    step(11'd40,  10'd600, 4'b0001, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b0, 4'h0, 12'h000);
    step(11'd799, 10'd599, 4'b0001, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b0, 4'h0, 12'h000);

    phase = "t4_cfg";
    step(11'd100, 10'd100, 4'b0001, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b1, 4'b1110, 12'h333);
    step(11'd101, 10'd100, 4'b0001, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b1, 4'b0000, 12'h0AA);
    step(11'd102, 10'd100, 4'b0000, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b0, 4'b0000, 12'h0AA);
    step(11'd0,   10'd0,   4'b0001, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b0, 4'h0, 12'h000);
    step(11'd1,   10'd0,   4'b0000, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b0, 4'h0, 12'h000);
    step(11'd2,   10'd0,   4'b0011, px(12'h0, 12'h0, 12'h0F0, 12'hFFF), 1'b0, 4'h0, 12'h000);

    phase = "t5_two_req";
    step(11'd50, 10'd50, 4'h0, 48'h0, 1'b1, 4'hF, 12'h111);
    step(11'd51, 10'd50, 4'h0, 48'h0, 1'b0, 4'hF, 12'h111);
    step(11'd52, 10'd50, 4'h0, 48'h0, 1'b1, 4'hF, 12'h222);
    step(11'd53, 10'd50, 4'h0, 48'h0, 1'b0, 4'hF, 12'h222);
    step(11'd0,  10'd0,  4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd1,  10'd0,  4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd0,  10'd0,  4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd1,  10'd0,  4'b0001, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b0, 4'h0, 12'h000);

    phase = "t6_same_idle";
    step(11'd0, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd5, 10'd0, 4'h0, 48'h0, 1'b1, 4'hF, 12'h444);
    step(11'd6, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd0, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd1, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);

    phase = "t6_same_pend";
    step(11'd20, 10'd0, 4'h0, 48'h0, 1'b1, 4'hF, 12'h555);
    step(11'd21, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd0,  10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd1,  10'd0, 4'h0, 48'h0, 1'b1, 4'hF, 12'h666);
    step(11'd2,  10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd0,  10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd1,  10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);

    phase = "t7_frames";
    do_reset();
    for (int f = 0; f < 3; f++) begin
      step(11'd0, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
      step(11'd1, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
      step(11'd2, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    end
    idle(1'b0);
    check("frame_cnt_is_3", 32'(frame_cnt), 32'd3);

    phase = "t8_rst_pend";
    step(11'd30, 10'd30, 4'h0, 48'h0, 1'b1, 4'h0, 12'h555);
    step(11'd31, 10'd30, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    do_reset();
    step(11'd0, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd1, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    step(11'd2, 10'd0, 4'b0001, px(12'h0, 12'h0, 12'h0, 12'hFFF), 1'b0, 4'h0, 12'h000);
    step(11'd0, 10'd0, 4'h0, 48'h0, 1'b0, 4'h0, 12'h000);
    idle(1'b0);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
